// File: rtl/player_pkg.sv
// Shared encodings for the player movement controller: move directions, FSM states, tile size.
package player_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int unsigned TILE_STEP = 16;

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin grant; the search starts at ptr and wraps (up, down, left, right).
module rr_arbiter4
  import player_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] gnt_idx,
  output logic       any
);

  // Walk offsets from farthest to nearest so the nearest request from ptr wins.
  always_comb begin
    gnt_idx = ptr;
    any     = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        gnt_idx = ptr + 2'(i);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/player_move_ctrl.sv
// Turns active-low key levels into rate-limited, bounds-checked single-tile move commands.
// Define KEY_SYNC_EN to pass each key through a 2-flop synchronizer (adds 2 cycles of latency).
module player_move_ctrl
  import player_pkg::*;
#(
  parameter int unsigned INIT_DELAY   = 12_500_000,
  parameter int unsigned REPEAT_DELAY = 4_000_000,
  parameter int unsigned STEP         = TILE_STEP,
  parameter int unsigned X_MIN        = 0,
  parameter int unsigned X_MAX        = 624,
  parameter int unsigned Y_MIN        = 0,
  parameter int unsigned Y_MAX        = 464
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       game_state,
  input  logic       keyUp,
  input  logic       keyDown,
  input  logic       keyLeft,
  input  logic       keyRight,
  input  logic [9:0] pos_x,
  input  logic [9:0] pos_y,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic       busy
);

  localparam int unsigned MAX_DELAY = (INIT_DELAY > REPEAT_DELAY) ? INIT_DELAY : REPEAT_DELAY;
  localparam int unsigned CNT_W     = (MAX_DELAY > 2) ? $clog2(MAX_DELAY) : 1;
  localparam logic [CNT_W-1:0] INIT_LAST   = CNT_W'(INIT_DELAY - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_DELAY - 1);

  logic [3:0] keys_raw;
  logic [3:0] keys_n;
  logic [3:0] held;
  logic [3:0] elig;
  logic [10:0] x_ext;
  logic [10:0] y_ext;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wait_last;
  logic [1:0]       rr_ptr;
  logic             first_flag;
  logic             wait_init;
  logic [1:0]       grant_idx;
  logic             grant_any;

  assign keys_raw = {keyRight, keyLeft, keyDown, keyUp};

`ifdef KEY_SYNC_EN
  logic [3:0] sync_a;
  logic [3:0] sync_b;

  // Only the hard reset clears the synchronizers; game_state leaves them running.
  always_ff @(posedge CLOCK_50) begin
    if (!reset) begin
      sync_a <= 4'hF;
      sync_b <= 4'hF;
    end else begin
      sync_a <= keys_raw;
      sync_b <= sync_a;
    end
  end

  assign keys_n = sync_b;
`else
  assign keys_n = keys_raw;
`endif

  assign held  = ~keys_n;
  assign x_ext = {1'b0, pos_x};
  assign y_ext = {1'b0, pos_y};

  assign elig[DIR_UP]    = held[DIR_UP]    && (y_ext >= 11'(Y_MIN + STEP));
  assign elig[DIR_DOWN]  = held[DIR_DOWN]  && ((y_ext + 11'(STEP)) <= 11'(Y_MAX));
  assign elig[DIR_LEFT]  = held[DIR_LEFT]  && (x_ext >= 11'(X_MIN + STEP));
  assign elig[DIR_RIGHT] = held[DIR_RIGHT] && ((x_ext + 11'(STEP)) <= 11'(X_MAX));

  rr_arbiter4 u_arb (
    .req     (elig),
    .ptr     (rr_ptr),
    .gnt_idx (grant_idx),
    .any     (grant_any)
  );

  assign wait_last = wait_init ? INIT_LAST : REPEAT_LAST;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge CLOCK_50) begin
    if (!reset || game_state) begin
      state      <= ST_IDLE;
      move_valid <= 1'b0;
      move_dir   <= DIR_UP;
      cnt        <= '0;
      rr_ptr     <= 2'd0;
      first_flag <= 1'b1;
      wait_init  <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (grant_any) begin
            state      <= ST_ISSUE;
            move_valid <= 1'b1;
            move_dir   <= grant_idx;
            first_flag <= 1'b1;
          end
        end
        ST_ISSUE: begin
          // The command is committed: key release or position change cannot withdraw it.
          if (move_valid && move_ready) begin
            state      <= ST_WAIT;
            move_valid <= 1'b0;
            rr_ptr     <= move_dir + 2'd1;
            cnt        <= '0;
            wait_init  <= first_flag;
            first_flag <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (held == 4'b0000) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == wait_last) begin
            // At the limit: hold here until a held key becomes legal again.
            if (grant_any) begin
              state      <= ST_ISSUE;
              move_valid <= 1'b1;
              move_dir   <= grant_idx;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state      <= ST_IDLE;
          move_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
